ne16_accumulator_drain: RTL and testbench
=========================================

NE16_ACCUMULATOR_DRAIN -- requirements
Module: ne16_accumulator_drain

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, accumulator address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, accumulator word width.
REQ-003 SHALL have parameter NUM_WORDS, default 2**ADDR_WIDTH, accumulator bank depth.
REQ-004 SHALL have parameter WIDTH_FACTOR, default 4, words per wide beat.
REQ-005 SHALL have port clk_i, input, 1, the single clock; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port clear_i, input, 1, synchronous abort to idle.
REQ-008 SHALL have port start_i, input, 1, one-cycle drain request, sampled only in IDLE.
REQ-009 SHALL have port len_i, input, ADDR_WIDTH+1, words to drain, sampled with start_i.
REQ-010 SHALL have port wide_i, input, 1, wide mode (WIDTH_FACTOR words/beat), sampled with start_i.
REQ-011 SHALL have port busy_o, output, 1, high outside IDLE.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse after the last handshake.
REQ-013 SHALL have port acc_re_o, output, 1, accumulator read enable.
REQ-014 SHALL have port acc_raddr_o, output, ADDR_WIDTH, accumulator read address.
REQ-015 SHALL have port acc_wide_enable_o, output, WIDTH_FACTOR, all-ones in wide mode, zero otherwise.
REQ-016 SHALL have port acc_rdata_wide_i, input, WIDTH_FACTOR*DATA_WIDTH, registered accumulator read data, valid one cycle after acc_re_o and held while acc_re_o low.
REQ-017 SHALL have port acc_clear_o, output, 1, accumulator clear request (see Configuration).
REQ-018 SHALL have port data_o, output, WIDTH_FACTOR*DATA_WIDTH, stream beat.
REQ-019 SHALL have port strb_o, output, WIDTH_FACTOR, per-word lane valid mask.
REQ-020 SHALL have ports valid_o (output, 1) and ready_i (input, 1), stream handshake; a beat transfers when both are high.

Function
REQ-021 SHALL implement FSM IDLE, READ, VALID, DONE.
REQ-022 IDLE->READ on start_i with effective length > 0; IDLE->DONE on start_i with len_i = 0 (no reads issued).
REQ-023 Effective length SHALL be min(len_i, NUM_WORDS).
REQ-024 READ: acc_re_o=1, acc_raddr_o=current address, exactly one cycle, then VALID.
REQ-025 VALID: valid_o=1, data_o=acc_rdata_wide_i; valid_o and data_o SHALL stay stable until ready_i.
REQ-026 On handshake: if words remain, advance address and go READ; else go DONE.
REQ-027 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-028 Address SHALL start at 0 and advance by WIDTH_FACTOR (wide) or 1 (narrow), wrapping modulo NUM_WORDS.
REQ-029 Narrow mode: strb_o = one-hot lane 0; upper lanes of data_o pass through unmodified.
REQ-030 Wide mode: strb_o = all-ones except final beat, where only remaining-word lanes (LSB first) are set.
REQ-031 Throughput SHALL be one beat per two cycles with ready_i held high.
REQ-032 start_i outside IDLE SHALL be ignored.
REQ-033 clear_i SHALL force IDLE next cycle from any state, drop valid_o, suppress done_o; clear_i takes priority over start_i.
REQ-034 valid_o, acc_re_o, done_o SHALL be zero in IDLE.

Reset
REQ-035 On rst_i: state=IDLE; busy_o, done_o, valid_o, acc_re_o, acc_clear_o = 0; address, counters, strb_o = 0.
REQ-036 rst_i mid-drain SHALL abort with no done_o pulse.

Configuration
REQ-037 With macro NE16_DRAIN_CLEAR_ON_DONE_EN defined, acc_clear_o SHALL pulse for one cycle concurrently with done_o.
REQ-038 Without it, acc_clear_o SHALL be tied to 0.

Structure
REQ-039 FSM state enum and drain-mode typedef SHALL live in ne16_package.
REQ-040 Address/remaining-word counter SHALL be one sub-module, ne16_drain_counter (load, step, remaining, last-beat flag).

Verification
REQ-041 Narrow, len_i=3, ready_i=1 -> raddr 0,1,2; three beats, strb 0001; done_o at cycle 7 after start.
REQ-042 Wide, WIDTH_FACTOR=4, len_i=10 -> raddr 0,4,8; strb 1111,1111,0011; one done_o.
REQ-043 Wide, len_i=32, ready_i low 5 cycles on beat 2 -> data_o/valid_o stable, no extra acc_re_o, 8 beats total.
REQ-044 len_i=0 -> no acc_re_o, no valid_o, done_o one cycle after start_i.
REQ-045 clear_i during VALID of beat 2 -> IDLE next cycle, valid_o=0, no done_o; new start_i restarts at raddr 0.
REQ-046 With NE16_DRAIN_CLEAR_ON_DONE_EN, len_i=4 wide -> acc_clear_o high exactly in the done_o cycle; without macro, never high.

Source files
------------

// File: rtl/ne16_package.sv
// Shared types for the NE16 accumulator drain: FSM state and drain mode.
package ne16_package;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  typedef enum logic {
    MODE_NARROW = 1'b0,
    MODE_WIDE   = 1'b1
  } drain_mode_e;

endpackage

// File: rtl/ne16_drain_counter.sv
// Drain address generator and remaining-word counter; the length is clamped
// to the bank depth on load and the address wraps modulo NUM_WORDS.
module ne16_drain_counter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_WORDS    = 2**ADDR_WIDTH,
  parameter int WIDTH_FACTOR = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  step_i,
  input  logic                  wide_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   remaining_o,
  output logic                  last_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH     = CW'(NUM_WORDS);
  localparam logic [CW-1:0] WIDE_STEP = CW'(WIDTH_FACTOR);

  logic [CW-1:0] inc;
  logic [CW-1:0] next_addr_raw;

  assign inc           = wide_i ? WIDE_STEP : CW'(1);
  assign next_addr_raw = {1'b0, addr_o} + inc;
  // The current beat is the last one when it consumes every remaining word.
  assign last_o        = (remaining_o <= inc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_o      <= '0;
      remaining_o <= '0;
    end else if (load_i) begin
      addr_o      <= '0;
      remaining_o <= (len_i > DEPTH) ? DEPTH : len_i;
    end else if (step_i) begin
      addr_o      <= (next_addr_raw >= DEPTH) ? ADDR_WIDTH'(next_addr_raw - DEPTH)
                                              : next_addr_raw[ADDR_WIDTH-1:0];
      remaining_o <= last_o ? '0 : remaining_o - inc;
    end
  end

endmodule

// File: rtl/ne16_accumulator_drain.sv
// Drains the accumulator bank onto a valid/ready stream, one beat per read.
// Optional feature: define NE16_DRAIN_CLEAR_ON_DONE_EN to pulse acc_clear_o with done_o.
module ne16_accumulator_drain
  import ne16_package::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WORDS    = 2**ADDR_WIDTH,
  parameter int WIDTH_FACTOR = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               start_i,
  input  logic [ADDR_WIDTH:0]                len_i,
  input  logic                               wide_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               acc_re_o,
  output logic [ADDR_WIDTH-1:0]              acc_raddr_o,
  output logic [WIDTH_FACTOR-1:0]            acc_wide_enable_o,
  input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] acc_rdata_wide_i,
  output logic                               acc_clear_o,
  output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data_o,
  output logic [WIDTH_FACTOR-1:0]            strb_o,
  output logic                               valid_o,
  input  logic                               ready_i
);

  drain_state_e        state;
  drain_mode_e         mode;
  logic [ADDR_WIDTH:0] remaining;
  logic                last;
  logic                load;
  logic                step;

  assign load = (state == ST_IDLE)  && start_i && !clear_i;
  assign step = (state == ST_VALID) && ready_i && !clear_i;

  ne16_drain_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NUM_WORDS    (NUM_WORDS),
    .WIDTH_FACTOR (WIDTH_FACTOR)
  ) u_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .len_i       (len_i),
    .step_i      (step),
    .wide_i      (mode == MODE_WIDE),
    .addr_o      (acc_raddr_o),
    .remaining_o (remaining),
    .last_o      (last)
  );

  // clear_i outranks everything, including a start_i in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      mode  <= MODE_NARROW;
    end else if (clear_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          mode  <= wide_i ? MODE_WIDE : MODE_NARROW;
          state <= (len_i == '0) ? ST_DONE : ST_READ;
        end
        ST_READ:  state <= ST_VALID;
        ST_VALID: if (ready_i) state <= last ? ST_DONE : ST_READ;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o            = (state != ST_IDLE);
  assign acc_re_o          = (state == ST_READ);
  assign valid_o           = (state == ST_VALID);
  assign done_o            = (state == ST_DONE);
  assign acc_wide_enable_o = (mode == MODE_WIDE) ? '1 : '0;
  // Read data is registered and held by the bank, so it is stable through stalls.
  assign data_o            = acc_rdata_wide_i;

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    strb_o = '0;
    if (state == ST_VALID) begin
      if (mode == MODE_NARROW) begin
        strb_o[0] = 1'b1;
      end else begin
        for (int i = 0; i < WIDTH_FACTOR; i++) begin
          strb_o[i] = !last || (i < int'(remaining));
        end
      end
    end
  end

`ifdef NE16_DRAIN_CLEAR_ON_DONE_EN
  assign acc_clear_o = done_o;
`else
  assign acc_clear_o = 1'b0;
`endif

endmodule

// File: tb/tb_ne16_accumulator_drain.sv
// Self-checking bench for ne16_accumulator_drain: beats are predicted from the
// drain rules over a random accumulator image and compared at each handshake.
module tb_ne16_accumulator_drain;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int WF = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [AW:0]     len_i = '0;
  logic            wide_i = 1'b0;
  logic            busy_o, done_o, acc_re_o, acc_clear_o, valid_o;
  logic [AW-1:0]   acc_raddr_o;
  logic [WF-1:0]   acc_wide_enable_o, strb_o;
  logic [WF*DW-1:0] acc_rdata = '0;
  logic [WF*DW-1:0] data_o;
  logic            ready_i = 1'b0;

  logic [DW-1:0]   mem [NW];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ne16_accumulator_drain #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .WIDTH_FACTOR(WF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .wide_i(wide_i), .busy_o(busy_o), .done_o(done_o),
    .acc_re_o(acc_re_o), .acc_raddr_o(acc_raddr_o),
    .acc_wide_enable_o(acc_wide_enable_o), .acc_rdata_wide_i(acc_rdata),
    .acc_clear_o(acc_clear_o), .data_o(data_o), .strb_o(strb_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  function automatic logic [WF*DW-1:0] window(input int a);
    logic [WF*DW-1:0] w;
    for (int i = 0; i < WF; i++) w[i*DW +: DW] = mem[(a + i) % NW];
    return w;
  endfunction

  // Accumulator bank: registered read, output held while no read is issued.
  always @(posedge clk) if (acc_re_o) acc_rdata <= window(int'(acc_raddr_o));

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    n_cmp++; if (acc_re_o !== 1'b0) begin n_err++; $display("FAIL reset_re got=%b want=0", acc_re_o); end
    n_cmp++; if (acc_clear_o !== 1'b0) begin n_err++; $display("FAIL reset_acc_clear got=%b want=0", acc_clear_o); end
    n_cmp++; if (strb_o !== '0) begin n_err++; $display("FAIL reset_strb got=%b want=0000", strb_o); end
    n_cmp++; if (acc_raddr_o !== '0) begin n_err++; $display("FAIL reset_raddr got=%0d want=0", acc_raddr_o); end
    rst_i = 1'b0;
  endtask

  // One complete drain with reference prediction and per-cycle checking.
  task automatic drain(input string name, input int len, input bit wide,
                       input int stall_beat, input int stall_len, input bit rnd_ready,
                       input bit noise_start, input int clear_beat);
    logic [AW-1:0]    e_addr[$];
    logic [WF-1:0]    e_strb[$];
    logic [WF*DW-1:0] e_data[$];
    logic [WF*DW-1:0] held_data;
    logic [WF-1:0]    held_strb;
    int n, rem, a, take, reads, beats, dones, clears, cyc, exp_done, done_cyc, clear_cyc, stall_left;
    bit holding, cleared, ended, rdy;

    n = (len > NW) ? NW : len;
    rem = n;
    a = 0;
    while (rem > 0) begin
      take = wide ? ((rem < WF) ? rem : WF) : 1;
      e_addr.push_back(AW'(a));
      e_strb.push_back(WF'((1 << take) - 1));
      e_data.push_back(window(a));
      rem -= take;
      a = (a + (wide ? WF : 1)) % NW;
    end
    exp_done = (n == 0) ? 1 : 2 * e_addr.size() + 1 + ((stall_beat < e_addr.size()) ? stall_len : 0);

    reads = 0; beats = 0; dones = 0; clears = 0; cyc = 0; done_cyc = -1; clear_cyc = -1;
    stall_left = stall_len; holding = 0; cleared = 0; ended = 0;
    held_data = '0; held_strb = '0;

    @(posedge clk);
    #1;
    start_i = 1'b1; len_i = (AW+1)'(len); wide_i = wide; ready_i = 1'b1;
    while (!ended) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cleared) begin
        n_cmp++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
          n_err++; $display("FAIL %s clear_to_idle busy=%b valid=%b want 0/0", name, busy_o, valid_o);
        end
        clear_i = 1'b0;
        ended = 1;
      end else if (!busy_o) begin
        ended = 1;
      end
      if (holding && !valid_o) begin
        n_cmp++; n_err++; $display("FAIL %s valid_dropped beat=%0d got=0 want=1", name, beats);
        holding = 0;
      end
      if (acc_re_o) begin
        n_cmp++;
        if (reads >= e_addr.size()) begin
          n_err++; $display("FAIL %s extra_read raddr=%0d reads=%0d want<=%0d", name, acc_raddr_o, reads + 1, e_addr.size());
        end else if (acc_raddr_o !== e_addr[reads]) begin
          n_err++; $display("FAIL %s raddr read=%0d got=%0d want=%0d", name, reads, acc_raddr_o, e_addr[reads]);
        end
        reads++;
      end
      if (done_o) begin dones++; done_cyc = cyc; end
      if (acc_clear_o) begin clears++; clear_cyc = cyc; end
      if (valid_o) begin
        if (holding) begin
          n_cmp++; if (data_o !== held_data || strb_o !== held_strb) begin
            n_err++; $display("FAIL %s stall_stable beat=%0d data=%h strb=%b want data=%h strb=%b",
                              name, beats, data_o, strb_o, held_data, held_strb);
          end
        end
        rdy = 1'b1;
        if (beats == stall_beat && stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else if (rnd_ready) rdy = 1'($urandom % 2);
        if (beats == clear_beat) begin clear_i = 1'b1; rdy = 1'b0; cleared = 1; end
        ready_i = rdy;
        if (rdy) begin
          n_cmp++;
          if (beats >= e_data.size()) begin
            n_err++; $display("FAIL %s extra_beat got=%0d want<=%0d", name, beats + 1, e_data.size());
          end else if (data_o !== e_data[beats] || strb_o !== e_strb[beats]) begin
            n_err++; $display("FAIL %s beat=%0d data=%h strb=%b want data=%h strb=%b",
                              name, beats, data_o, strb_o, e_data[beats], e_strb[beats]);
          end
          beats++;
          holding = 0;
        end else begin
          holding = !cleared;
          held_data = data_o;
          held_strb = strb_o;
        end
      end else begin
        ready_i = 1'($urandom % 2);
      end
      start_i = (noise_start && !ended && busy_o) ? 1'($urandom % 2) : 1'b0;
      len_i = noise_start ? (AW+1)'($urandom) : len_i;
      wide_i = noise_start ? 1'($urandom) : wide_i;
      if (!ended && cyc > 400) begin
        n_cmp++; n_err++; $display("FAIL %s timeout busy=%b after %0d cycles", name, busy_o, cyc);
        ended = 1;
      end
    end
    start_i = 1'b0;
    ready_i = 1'b0;

    n_cmp++; if (beats != (cleared ? clear_beat : e_data.size())) begin
      n_err++; $display("FAIL %s beat_count got=%0d want=%0d", name, beats, cleared ? clear_beat : e_data.size());
    end
    n_cmp++; if (reads != (cleared ? clear_beat + 1 : e_addr.size())) begin
      n_err++; $display("FAIL %s read_count got=%0d want=%0d", name, reads, cleared ? clear_beat + 1 : e_addr.size());
    end
    n_cmp++; if (dones != (cleared ? 0 : 1)) begin
      n_err++; $display("FAIL %s done_count got=%0d want=%0d", name, dones, cleared ? 0 : 1);
    end
    if (!cleared && !rnd_ready) begin
      n_cmp++; if (done_cyc != exp_done) begin
        n_err++; $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_done);
      end
    end
`ifdef NE16_DRAIN_CLEAR_ON_DONE_EN
    n_cmp++; if (clears != (cleared ? 0 : 1) || clear_cyc != done_cyc) begin
      n_err++; $display("FAIL %s acc_clear pulses=%0d at=%0d want=%0d at=%0d",
                        name, clears, clear_cyc, cleared ? 0 : 1, done_cyc);
    end
`else
    n_cmp++; if (clears != 0) begin
      n_err++; $display("FAIL %s acc_clear pulses=%0d want=0", name, clears);
    end
`endif
  endtask

  task automatic test_narrow();
    drain("narrow_len3", 3, 1'b0, -1, 0, 1'b0, 1'b0, -1);
    drain("narrow_len1", 1, 1'b0, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wide();
    drain("wide_len10", 10, 1'b1, -1, 0, 1'b0, 1'b0, -1);
    drain("wide_len4", 4, 1'b1, -1, 0, 1'b0, 1'b0, -1);
    n_cmp++; if (acc_wide_enable_o !== '1) begin
      n_err++; $display("FAIL wide_enable got=%b want=1111", acc_wide_enable_o);
    end
  endtask

  task automatic test_stall();
    drain("wide_len32_stall", 32, 1'b1, 1, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_len_zero();
    drain("len0", 0, 1'b1, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_clamp();
    drain("wide_len63", 63, 1'b1, -1, 0, 1'b0, 1'b0, -1);
    drain("narrow_len40", 40, 1'b0, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_clear();
    drain("clear_beat2", 32, 1'b1, -1, 0, 1'b0, 1'b0, 1);
    drain("restart_after_clear", 5, 1'b0, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drain($sformatf("rand%0d", i), int'($urandom_range(0, 63)), 1'($urandom), -1, 0, 1'b1, 1'b1, -1);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit seen;
    @(posedge clk);
    #1;
    start_i = 1'b1; len_i = 6'd32; wide_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || acc_re_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drain busy=%b valid=%b re=%b want 0/0/0", busy_o, valid_o, acc_re_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) seen = 1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL rst_mid_drain activity_after_reset got=1 want=0"); end
    ready_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    test_reset();
    test_narrow();
    test_wide();
    test_stall();
    test_len_zero();
    test_clamp();
    test_clear();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
